pc_ret_stack: RTL and testbench
===============================

PC_RET_STACK -- requirements
Module: pc_ret_stack

Interface
REQ-001 Parameter ADDR_W, default 8: program-counter and return-address width in bits.
REQ-002 Parameter DEPTH, default 4: return-stack entries; power of two, at least 2.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous, active-high.
REQ-005 Port en, input, 1: step enable; low means hold all state, including stack, pc and flags.
REQ-006 Port jump1, input, 1: load pc from target this step.
REQ-007 Port ret1, input, 1: pop the return stack into pc this step.
REQ-008 Port push1, input, 1: push the return address (pc+1) this step; with jump1 this is a call.
REQ-009 Port target, input, ADDR_W: jump destination.
REQ-010 Port pc, output, ADDR_W: current program counter, registered.
REQ-011 Port depth, output, clog2(DEPTH)+1: number of valid stack entries, registered.
REQ-012 Port empty, output, 1: asserted when depth==0.
REQ-013 Port full, output, 1: asserted when depth==DEPTH.
REQ-014 Port ovf, output, 1: sticky overflow error.
REQ-015 Port unf, output, 1: sticky underflow error.

Function
REQ-016 All arithmetic on pc shall be modulo 2^ADDR_W; pc+1 from all-ones wraps to 0.
REQ-017 With en=1, pc_next priority shall be: ret1 first, then jump1, then pc+1.
REQ-018 ret1 with depth>0: pc <= top entry; depth decrements by 1; latency is one clock.
REQ-019 ret1 with depth==0: pc <= pc+1; depth stays 0; unf set.
REQ-020 ret1 has priority, so push1 and jump1 shall be ignored in any cycle where ret1=1.
REQ-021 push1 without ret1 and depth<DEPTH: the value pc+1, computed from pre-edge pc, is written at index depth; depth increments.
REQ-022 push1 without ret1 and depth==DEPTH: push is dropped; stack contents and depth are unchanged; ovf set; pc still updates per REQ-017.
REQ-023 jump1 with push1 (call): pc <= target and pc+1 is pushed, both in the same edge.
REQ-024 push1 alone: pc <= pc+1 and pc+1 is pushed.
REQ-025 jump1 alone: pc <= target; stack is untouched.
REQ-026 With no request: pc <= pc+1.
REQ-027 ovf and unf remain set until rst; no other event clears them.
REQ-028 empty and full shall be decoded combinationally from registered depth, with no extra latency.
REQ-029 The top entry (index depth-1) shall be readable by ret1 in the cycle immediately after the push that wrote it.
REQ-030 Stack storage contents above depth are don't-care and shall never reach pc.

Reset
REQ-031 With rst=1 at a clock edge: pc=0, depth=0, ovf=0, unf=0; this holds regardless of en, jump1, ret1 and push1.
REQ-032 rst mid-operation shall discard all stack entries logically; storage RAM need not be cleared.
REQ-033 On the first edge after rst deasserts, with en=1 and no request, pc shall become 1.

Verification
REQ-034 Reset then 3 idle enabled clocks -> pc = 1, 2, 3; empty=1.
REQ-035 At pc=0x10, call with target=0x40; 2 idle clocks; ret1 -> pc = 0x40, 0x41, 0x42, then 0x11; depth goes 1 then 0.
REQ-036 From empty, 4 calls then a 5th call -> full=1 after the 4th; on the 5th, ovf=1, depth=4 and pc=target; 4 returns then restore the 4 addresses in LIFO order.
REQ-037 ret1 with empty stack at pc=0x20 -> pc=0x21, unf=1, depth=0; unf still 1 after 10 clocks.
REQ-038 ret1+jump1+push1 together at depth=1 (top=0x55) -> pc=0x55, depth=0, no push; also en=0 for 3 clocks -> pc, depth and flags frozen.
REQ-039 At pc=0xFF, idle -> pc=0x00; separately, rst asserted at depth=3 -> next cycle pc=0, depth=0, empty=1.

Source files
------------

// File: rtl/pc_ret_stack.sv
// pc_ret_stack: program counter with a small LIFO return-address stack.
// A call (jump1+push1) saves pc+1 and loads target. A return (ret1) pops
// the saved address back into pc. Overflow and underflow raise sticky
// error flags. Storage is not reset; depth alone decides which entries
// are valid.
module pc_ret_stack #(
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic                       jump1,
   input  logic                       ret1,
   input  logic                       push1,
   input  logic [ADDR_W-1:0]          target,
   output logic [ADDR_W-1:0]          pc,
   output logic [$clog2(DEPTH):0]     depth,
   output logic                       empty,
   output logic                       full,
   output logic                       ovf,
   output logic                       unf
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int DW    = PTR_W + 1;
   localparam logic [DW-1:0] FULL_CNT = DW'(DEPTH);
   localparam logic [DW-1:0] ONE_CNT  = DW'(1);

   logic [ADDR_W-1:0] r_stack [DEPTH];
   logic [ADDR_W-1:0] r_pc;
   logic [DW-1:0]     r_depth;
   logic              r_ovf;
   logic              r_unf;

   logic [ADDR_W-1:0] w_pc_inc;
   logic [DW-1:0]     w_depth_dec;
   logic [PTR_W-1:0]  w_top_idx;
   logic [PTR_W-1:0]  w_wr_idx;
   logic              w_empty;
   logic              w_full;
   logic              w_push_ok;

   // Return address and stack pointers. pc+1 wraps naturally at ADDR_W bits.
   // The write index is only used when depth<DEPTH, so it fits in PTR_W bits.
   always_comb begin
      w_pc_inc    = r_pc + ADDR_W'(1);
      w_depth_dec = r_depth - ONE_CNT;
      w_top_idx   = w_depth_dec[PTR_W-1:0];
      w_wr_idx    = r_depth[PTR_W-1:0];
      w_empty     = (r_depth == '0);
      w_full      = (r_depth == FULL_CNT);
      w_push_ok   = en && !ret1 && push1 && !w_full;
   end

   // Stack storage: written only by an accepted push, never reset.
   always_ff @(posedge clk) begin
      if (!rst && w_push_ok) begin
         r_stack[w_wr_idx] <= w_pc_inc;
      end
   end

   // pc, depth and sticky flags. ret1 overrides jump1 and push1 entirely.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc    <= '0;
         r_depth <= '0;
         r_ovf   <= 1'b0;
         r_unf   <= 1'b0;
      end else if (en) begin
         if (ret1) begin
            if (!w_empty) begin
               r_pc    <= r_stack[w_top_idx];
               r_depth <= w_depth_dec;
            end else begin
               r_pc  <= w_pc_inc;
               r_unf <= 1'b1;
            end
         end else begin
            r_pc <= jump1 ? target : w_pc_inc;
            if (push1) begin
               if (!w_full) begin
                  r_depth <= r_depth + ONE_CNT;
               end else begin
                  r_ovf <= 1'b1;
               end
            end
         end
      end
   end

   assign pc    = r_pc;
   assign depth = r_depth;
   assign empty = w_empty;
   assign full  = w_full;
   assign ovf   = r_ovf;
   assign unf   = r_unf;

endmodule

// File: tb/tb_pc_ret_stack.sv
// tb_pc_ret_stack: directed vector table, hand-written corner sequences and
// randomized traffic against a queue-based reference model.
module tb_pc_ret_stack;

   localparam int ADDR_W = 8;
   localparam int DEPTH  = 4;

   logic              clk;
   logic              rst;
   logic              en;
   logic              jump1;
   logic              ret1;
   logic              push1;
   logic [ADDR_W-1:0] target;
   logic [ADDR_W-1:0] pc;
   logic [2:0]        depth;
   logic              empty;
   logic              full;
   logic              ovf;
   logic              unf;

   pc_ret_stack #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .en(en), .jump1(jump1), .ret1(ret1),
      .push1(push1), .target(target), .pc(pc), .depth(depth),
      .empty(empty), .full(full), .ovf(ovf), .unf(unf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Reference model: pc as an integer, stack as a queue (back = top).
   int m_pc  = 0;
   int m_stk [$];
   bit m_ovf = 0;
   bit m_unf = 0;

   typedef struct {
      bit rs, e, j, r, p;
      int t;
      int epc, ed;
      bit eo, eu;
   } vec_t;
   vec_t tv [$];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic addv(input bit rs, e, j, r, p, input int t,
                       input int epc, ed, input bit eo, eu);
      vec_t v;
      v.rs = rs; v.e = e; v.j = j; v.r = r; v.p = p; v.t = t;
      v.epc = epc; v.ed = ed; v.eo = eo; v.eu = eu;
      tv.push_back(v);
   endtask

   // Drive one step, advance the model by the spec rules, wait past the edge.
   task automatic apply(input bit a_rst, a_en, a_j, a_r, a_p, input int a_t);
      int inc;
      rst = a_rst; en = a_en; jump1 = a_j; ret1 = a_r; push1 = a_p;
      target = ADDR_W'(a_t);
      if (a_rst) begin
         m_pc = 0; m_stk.delete(); m_ovf = 0; m_unf = 0;
      end else if (a_en) begin
         inc = (m_pc + 1) % 256;
         if (a_r) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else begin m_pc = inc; m_unf = 1; end
         end else begin
            if (a_p) begin
               if (m_stk.size() < DEPTH) m_stk.push_back(inc);
               else m_ovf = 1;
            end
            m_pc = a_j ? (a_t % 256) : inc;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic chk_model(input string tag);
      chk({tag, " pc"},    int'(pc),    m_pc);
      chk({tag, " depth"}, int'(depth), m_stk.size());
      chk({tag, " empty"}, int'(empty), int'(m_stk.size() == 0));
      chk({tag, " full"},  int'(full),  int'(m_stk.size() == DEPTH));
      chk({tag, " ovf"},   int'(ovf),   int'(m_ovf));
      chk({tag, " unf"},   int'(unf),   int'(m_unf));
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; jump1 = 1'b0; ret1 = 1'b0; push1 = 1'b0;
      target = '0;
      @(posedge clk);
      #1;

      // ---------------- directed vector table ----------------
      //   rst en  j  r  p  target   pc  depth ovf unf
      addv(1, 1, 1, 0, 1, 8'h33,   8'h00, 0, 0, 0);  // reset wins over requests
      addv(0, 1, 0, 0, 0, 0,       8'h01, 0, 0, 0);
      addv(0, 1, 0, 0, 0, 0,       8'h02, 0, 0, 0);
      addv(0, 1, 0, 0, 0, 0,       8'h03, 0, 0, 0);
      addv(0, 1, 1, 0, 0, 8'h10,   8'h10, 0, 0, 0);
      addv(0, 1, 1, 0, 1, 8'h40,   8'h40, 1, 0, 0);  // call, saves 0x11
      addv(0, 1, 0, 0, 0, 0,       8'h41, 1, 0, 0);
      addv(0, 1, 0, 0, 0, 0,       8'h42, 1, 0, 0);
      addv(0, 1, 0, 1, 0, 0,       8'h11, 0, 0, 0);  // return
      addv(0, 1, 1, 0, 0, 8'h20,   8'h20, 0, 0, 0);
      addv(0, 1, 0, 1, 0, 0,       8'h21, 0, 0, 1);  // underflow
      addv(0, 1, 1, 0, 0, 8'h54,   8'h54, 0, 0, 1);
      addv(0, 1, 0, 0, 1, 0,       8'h55, 1, 0, 1);  // push alone saves 0x55
      addv(0, 1, 1, 1, 1, 8'h99,   8'h55, 0, 0, 1);  // ret wins over jump+push
      addv(0, 0, 1, 1, 1, 8'h77,   8'h55, 0, 0, 1);  // en=0 freezes
      addv(0, 0, 0, 0, 1, 8'h77,   8'h55, 0, 0, 1);
      addv(0, 0, 1, 0, 0, 8'h77,   8'h55, 0, 0, 1);
      addv(0, 1, 1, 0, 0, 8'hFF,   8'hFF, 0, 0, 1);
      addv(0, 1, 0, 0, 0, 0,       8'h00, 0, 0, 1);  // pc wraps
      addv(0, 1, 0, 0, 1, 0,       8'h01, 1, 0, 1);
      addv(0, 1, 0, 0, 1, 0,       8'h02, 2, 0, 1);
      addv(0, 1, 0, 0, 1, 0,       8'h03, 3, 0, 1);
      addv(0, 1, 1, 1, 0, 8'h44,   8'h00, 0, 0, 0);  // no-op row replaced below
      tv[tv.size()-1].rs = 1;                         // rst at depth=3
      addv(0, 1, 0, 0, 0, 0,       8'h01, 0, 0, 0);  // first edge after reset

      foreach (tv[i]) begin
         apply(tv[i].rs, tv[i].e, tv[i].j, tv[i].r, tv[i].p, tv[i].t);
         chk($sformatf("vec%0d pc", i),    int'(pc),    tv[i].epc);
         chk($sformatf("vec%0d depth", i), int'(depth), tv[i].ed);
         chk($sformatf("vec%0d empty", i), int'(empty), int'(tv[i].ed == 0));
         chk($sformatf("vec%0d full", i),  int'(full),  int'(tv[i].ed == DEPTH));
         chk($sformatf("vec%0d ovf", i),   int'(ovf),   int'(tv[i].eo));
         chk($sformatf("vec%0d unf", i),   int'(unf),   int'(tv[i].eu));
      end

      // ---------------- overflow: 4 calls fill, 5th dropped ----------------
      apply(1, 0, 0, 0, 0, 0);
      apply(0, 1, 1, 0, 0, 8'h10);
      for (int k = 0; k < 4; k++) apply(0, 1, 1, 0, 1, 8'h30 + 8'h20 * k);
      chk("ovf4 full", int'(full), 1);
      chk("ovf4 ovf",  int'(ovf),  0);
      apply(0, 1, 1, 0, 1, 8'hB0);
      chk("ovf5 ovf",   int'(ovf),   1);
      chk("ovf5 depth", int'(depth), 4);
      chk("ovf5 pc",    int'(pc),    8'hB0);
      begin
         int exp_ret [4] = '{8'h71, 8'h51, 8'h31, 8'h11};
         for (int k = 0; k < 4; k++) begin
            apply(0, 1, 0, 1, 0, 0);
            chk($sformatf("lifo%0d pc", k), int'(pc), exp_ret[k]);
         end
      end
      chk("lifo empty", int'(empty), 1);
      chk("lifo ovf sticky", int'(ovf), 1);
      chk_model("ovf-seq");

      // ---------------- underflow is sticky ----------------
      apply(1, 0, 0, 0, 0, 0);
      apply(0, 1, 1, 0, 0, 8'h20);
      apply(0, 1, 0, 1, 0, 0);
      chk("unf pc",    int'(pc),    8'h21);
      chk("unf depth", int'(depth), 0);
      chk("unf flag",  int'(unf),   1);
      for (int k = 0; k < 10; k++) apply(0, 1, k[0], 0, 0, 8'h80);
      chk("unf sticky", int'(unf), 1);

      // ---------------- randomized traffic vs model ----------------
      for (int k = 0; k < 400; k++) begin
         apply(($urandom_range(0, 59) == 0),
               ($urandom_range(0, 7) != 0),
               1'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom),
               int'($urandom_range(0, 255)));
         chk_model($sformatf("rnd%0d", k));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
